mips_multicycle_core: RTL and testbench

- Parametrised multicycle MIPS-subset core.
- Successor to the fixed 8-bit, fixed-program processor. Adds configurable data width, register count, PC width and start/halt addresses.
- Adds external instruction and data memory ports, with a variable-latency data handshake, and a `sw` store path.
- Replaces `$display`/`$finish` result reporting with a halt flag and a debug register-read port. The bench or SoC top samples results through these.

---
 rtl/mips_multicycle_core.sv | 114 +++++++++++
 tb/tb_mips_multicycle_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: parametrised multicycle MIPS-subset core with external
// instruction/data memory ports, a halt flag and a debug register-read port.
module mips_multicycle_core #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 8,
  parameter int START_PC = 12,
  parameter int HALT_PC  = 14,
  parameter int DADDR_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [31:0]        imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  input  logic [4:0]         dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               halted,
  output logic               illegal
);
  localparam int RW = $clog2(NUM_REGS);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, simm, alu;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic ill_q, unused;
  logic [5:0] op, fn;
  logic [RW-1:0] rs, rt, rd, wdest;
  logic rtype, is_addu, is_subu, is_slt, is_jr, is_addiu, is_beq, is_bne;
  logic is_lw, is_sw, is_halt, is_j, is_jal, legal, wen, taken;
  assign op       = ir_q[31:26];
  assign fn       = ir_q[5:0];
  assign rs       = ir_q[21 +: RW];
  assign rt       = ir_q[16 +: RW];
  assign rd       = ir_q[11 +: RW];
  assign simm     = DATA_W'($signed(ir_q[15:0]));
  assign rtype    = op == 6'h00;
  assign is_addu  = rtype && fn == 6'h21;
  assign is_subu  = rtype && fn == 6'h23;
  assign is_slt   = rtype && fn == 6'h2A;
  assign is_jr    = rtype && fn == 6'h08;
  assign is_addiu = op == 6'h09;
  assign is_beq   = op == 6'h04;
  assign is_bne   = op == 6'h05;
  assign is_lw    = op == 6'h23;
  assign is_sw    = op == 6'h2B;
  assign is_halt  = op == 6'h3F;
  assign is_j     = op == 6'h02;
  assign is_jal   = op == 6'h03;
  assign legal    = is_addu || is_subu || is_slt || is_jr || is_addiu || is_beq || is_bne ||
                    is_lw || is_sw || is_halt || is_j || is_jal;
  assign wen      = is_addu || is_subu || is_slt || is_addiu || is_lw || is_jal;
  assign wdest    = is_jal ? {RW{1'b1}} : (is_addiu || is_lw) ? rt : rd;
  assign taken    = (is_beq && a_q == b_q) || (is_bne && a_q != b_q);
  // jal links the already-incremented pc; loads/stores reuse the adder for addresses
  assign alu = is_addu ? a_q + b_q :
               is_subu ? a_q - b_q :
               is_slt  ? DATA_W'($signed(a_q) < $signed(b_q)) :
               is_jal  ? DATA_W'(pc_q) : a_q + simm;
  assign imem_addr  = pc_q;
  assign dmem_req   = state_q == MEM;
  assign dmem_we    = state_q == MEM && is_sw;
  assign dmem_addr  = DADDR_W'(res_q);
  assign dmem_wdata = b_q;
  assign dbg_data   = rf_q[dbg_addr[RW-1:0]];
  assign halted     = state_q == HALT;
  assign illegal    = ill_q;
  assign unused     = ^{ir_q[10:6], dbg_addr};
  always_comb begin
    state_d = state_q == FETCH  ? DECODE :
              state_q == DECODE ? EXEC :
              state_q == EXEC   ? ((is_lw || is_sw) ? MEM : WB) :
              state_q == MEM    ? (dmem_ready ? WB : MEM) :
              state_q == WB     ? ((is_halt || pc_q == PC_W'(HALT_PC)) ? HALT : FETCH) : HALT;
    pc_d = state_q == FETCH      ? pc_q + 1'b1 :
           state_q != EXEC       ? pc_q :
           is_jr                 ? PC_W'(a_q) :
           (is_j || is_jal)      ? PC_W'(ir_q[25:0]) :
           taken                 ? PC_W'(ir_q[15:0]) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= PC_W'(START_PC);
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == FETCH) ir_q <= imem_data;
      if (state_q == DECODE) begin
        a_q <= rf_q[rs];
        b_q <= rf_q[rt];
      end
      if (state_q == EXEC) begin
        res_q <= alu;
        ill_q <= ill_q | ~legal;
      end
      if (state_q == MEM && dmem_ready && !is_sw) res_q <= dmem_rdata;
      if (state_q == WB && wen && wdest != '0) rf_q[wdest] <= res_q;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: scoreboard bench; stimulus queues expectations, monitors
// pop and compare them against the halt/illegal/pc/debug ports and dmem handshakes.
module tb_mips_multicycle_core;
  localparam int H0 = 0, I0 = 1, D0 = 2, P0 = 3, Q0 = 4, H1 = 5, I1 = 6, D1 = 7, P1 = 8;
  localparam logic [31:0] HALTW = 32'hFC00_0000;
  logic clk = 0, rst0 = 1, rst1 = 1;
  always #10 clk = ~clk;
  logic [31:0] im0 [256];
  logic [31:0] im1 [256];
  logic [7:0] pc0, pc1, wd0, rd0, dbg0;
  logic [15:0] wd1, dbg1;
  logic [3:0] addr0, addr1;
  logic req0, we0, rdy0, hlt0, ill0, req1, we1, hlt1, ill1;
  logic [4:0] da = 0;
  logic [7:0] dm [16];
  int nwait = 3, wcnt = 0;
  assign rdy0 = req0 && (wcnt == nwait);
  assign rd0 = dm[addr0];
  always @(posedge clk) begin
    wcnt <= (req0 && !rdy0) ? wcnt + 1 : 0;
    if (req0 && rdy0 && we0) dm[addr0] <= wd0;
  end
  mips_multicycle_core u0 (
    .clk(clk), .reset(rst0), .imem_addr(pc0), .imem_data(im0[pc0]),
    .dmem_req(req0), .dmem_we(we0), .dmem_addr(addr0), .dmem_wdata(wd0),
    .dmem_rdata(rd0), .dmem_ready(rdy0), .dbg_addr(da), .dbg_data(dbg0),
    .halted(hlt0), .illegal(ill0));
  mips_multicycle_core #(.DATA_W(16), .NUM_REGS(8), .HALT_PC(100)) u1 (
    .clk(clk), .reset(rst1), .imem_addr(pc1), .imem_data(im1[pc1]),
    .dmem_req(req1), .dmem_we(we1), .dmem_addr(addr1), .dmem_wdata(wd1),
    .dmem_rdata(16'h0), .dmem_ready(1'b0), .dbg_addr(da), .dbg_data(dbg1),
    .halted(hlt1), .illegal(ill1));
  typedef struct { string nm; int sel; int da; logic [31:0] exp; } chk_t;
  typedef struct { logic we; logic [3:0] a; logic [7:0] d; int cyc; } mem_t;
  chk_t sb[$];
  mem_t mq[$];
  chk_t ce;
  mem_t me;
  logic [31:0] act;
  int n_cmp = 0, n_bad = 0, mcnt = 0;
  bit busy = 0;
  int bop[4] = '{4, 4, 5, 5};
  int bv[4]  = '{3, 4, 3, 4};
  int bpc[4] = '{20, 53, 53, 20};
  function automatic logic [31:0] fi(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] fr(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] fj(int op, int t);
    return {6'(op), 26'(t)};
  endfunction
  task automatic want(string nm, int sel, logic [31:0] exp, int r = 0);
    sb.push_back('{nm, sel, r, exp});
  endtask
  task automatic settle;
    while (sb.size() != 0 || busy) #1;
  endtask
  task automatic run(int n);
    settle();
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic reset0;
    rst0 = 1;
    run(1);
    want("rst pc0", P0, 12); want("rst halted0", H0, 0);
    want("rst illegal0", I0, 0); want("rst req0", Q0, 0);
    settle();
    rst0 = 0;
  endtask
  // scoreboard monitor: drives the debug index of each entry, then samples
  initial forever begin
    #1;
    while (sb.size() != 0) begin
      busy = 1;
      ce = sb.pop_front();
      da = 5'(ce.da);
      #1;
      case (ce.sel)
        H0: act = 32'(hlt0);
        I0: act = 32'(ill0);
        D0: act = 32'(dbg0);
        P0: act = 32'(pc0);
        Q0: act = 32'(req0);
        H1: act = 32'(hlt1);
        I1: act = 32'(ill1);
        D1: act = 32'(dbg1);
        default: act = 32'(pc1);
      endcase
      n_cmp++;
      if (act !== ce.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h, expected %0h", ce.nm, act, ce.exp);
      end
      busy = 0;
    end
  end
  // dmem monitor: counts request cycles and checks each completed access
  always @(negedge clk) begin
    if (rst0) mcnt = 0;
    else if (req0) begin
      mcnt++;
      if (rdy0) begin
        n_cmp++;
        if (mq.size() == 0) begin
          n_bad++;
          $display("FAIL dmem unexpected: we=%0b addr=%0h, expected no access", we0, addr0);
        end else begin
          me = mq.pop_front();
          if (me.we !== we0 || me.a !== addr0 || (me.we && me.d !== wd0) || me.cyc != mcnt) begin
            n_bad++;
            $display("FAIL dmem access: got we=%0b addr=%0h wdata=%0h req_cycles=%0d, expected we=%0b addr=%0h wdata=%0h req_cycles=%0d",
                     we0, addr0, wd0, mcnt, me.we, me.a, me.d, me.cyc);
          end
        end
        mcnt = 0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      im0[i] = HALTW;
      im1[i] = HALTW;
    end
    // 16-bit core, 8 registers: slt signedness, r0 writes, illegal opcode, halt op
    im1[12] = fi(9, 0, 1, 16'h8000);
    im1[13] = fi(9, 0, 2, 1);
    im1[14] = fr(1, 2, 4, 6'h2A);
    im1[15] = fi(9, 0, 0, 9);
    im1[16] = {6'h3E, 26'd0};
    im1[17] = fr(2, 1, 5, 6'h23);
    im1[18] = fr(2, 2, 7, 6'h21);
    im1[19] = HALTW;
    rst1 = 1;
    run(1);
    want("rst pc1", P1, 12); want("rst halted1", H1, 0); want("rst illegal1", I1, 0);
    settle();
    rst1 = 0;
    run(12);
    want("slt r4", D1, 1, 4); want("addiu r1 sext", D1, 32'h8000, 1); want("pc after 3 instr", P1, 15);
    run(4);
    want("r0 stays 0", D1, 0, 0); want("illegal before 0x3E", I1, 0);
    run(4);
    want("illegal after 0x3E", I1, 1); want("pc after illegal", P1, 17);
    run(8);
    want("subu r5", D1, 32'h8001, 5); want("addu r7", D1, 2, 7); want("illegal sticky", I1, 1);
    run(3);
    want("halted1 before halt WB", H1, 0);
    run(1);
    want("halted1 after halt op", H1, 1); want("pc1 at halt", P1, 20);
    run(4);
    want("pc1 frozen", P1, 20); want("halted1 held", H1, 1);
    // default core: pc reaches HALT_PC=14 at the end of the second addiu's WB
    im0[12] = fi(9, 0, 2, 5);
    im0[13] = fi(9, 2, 2, -7);
    im0[14] = HALTW;
    reset0();
    run(7);
    want("halted0 before", H0, 0);
    run(1);
    want("halted0 at HALT_PC", H0, 1); want("r2 = 5-7", D0, 8'hFE, 2);
    want("illegal0 clean", I0, 0); want("pc0 at halt", P0, 14);
    run(12);
    want("pc0 frozen", P0, 14); want("halted0 held", H0, 1);
    for (int k = 0; k < 4; k++) begin
      im0[12] = fj(2, 50);
      im0[50] = fi(9, 0, 1, 3);
      im0[51] = fi(9, 0, 3, bv[k]);
      im0[52] = fi(bop[k], 1, 3, 20);
      reset0();
      run(16);
      want($sformatf("branch%0d pc", k), P0, 32'(bpc[k]));
      want($sformatf("branch%0d r3", k), D0, 32'(bv[k]), 3);
    end
    nwait = 3;
    im0[12] = fj(2, 50);
    im0[50] = fi(9, 0, 5, 8'h5A);
    im0[51] = fi(6'h2B, 0, 5, 2);
    im0[52] = fi(6'h23, 0, 6, 2);
    mq.push_back('{1'b1, 4'd2, 8'h5A, 4});
    mq.push_back('{1'b0, 4'd2, 8'h00, 4});
    reset0();
    run(24);
    want("pc after sw/lw", P0, 53); want("lw r6", D0, 8'h5A, 6); want("r5", D0, 8'h5A, 5);
    im0[12] = fi(9, 0, 1, 1);
    im0[13] = fj(3, 40);
    im0[40] = fr(31, 0, 0, 8);
    reset0();
    run(8);
    want("pc after jal", P0, 40); want("jal r31", D0, 14, 31); want("halted0 after jal", H0, 0);
    run(3);
    want("halted0 before jr WB", H0, 0);
    run(1);
    want("halted0 after jr", H0, 1); want("pc0 after jr", P0, 14);
    nwait = 1000;
    im0[12] = fj(2, 50);
    im0[50] = fi(6'h23, 0, 6, 2);
    reset0();
    run(9);
    want("lw pending req", Q0, 1); want("r6 before reset", D0, 0, 6);
    settle();
    rst0 = 1;
    run(1);
    want("req drops on reset", Q0, 0); want("pc reset mid-lw", P0, 12);
    want("r6 unchanged", D0, 0, 6); want("halted0 reset mid-lw", H0, 0);
    settle();
    rst0 = 0;
    run(2);
    settle();
    n_cmp++;
    if (mq.size() != 0) begin
      n_bad++;
      $display("FAIL dmem outstanding: got %0d accesses missing, expected 0", mq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
